// File: rtl/hidden_output_layer.sv
// hidden_output_layer: time-multiplexed signed MAC computing bias + weighted sums per output neuron.
// Define HIDDEN_OUTPUT_SAT_EN to clamp out-of-range results instead of wrapping.
module hidden_output_layer #(
    parameter int Q              = 13,
    parameter int N              = 16,
    parameter int NUM_OF_INPUTS  = 2,
    parameter int NUM_OF_OUTPUTS = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [N*NUM_OF_INPUTS-1:0]                 i_data_in,
    input  logic [N*NUM_OF_INPUTS*NUM_OF_OUTPUTS-1:0]  i_weight_mem,
    input  logic [N*NUM_OF_OUTPUTS-1:0]                i_bias_mem,
    input  logic                                       i_fire,
    output logic [N*NUM_OF_OUTPUTS-1:0]                o_data_out,
    output logic                                       o_busy,
    output logic                                       o_done,
    output logic                                       o_overflow
);
    localparam int NI = NUM_OF_INPUTS;
    localparam int NO = NUM_OF_OUTPUTS;
    localparam int AW = 2*N + $clog2(NI) + 1;
    localparam int IW = NI > 1 ? $clog2(NI) : 1;
    localparam int OW = NO > 1 ? $clog2(NO) : 1;

    typedef enum logic [1:0] {IDLE, MAC, WB} state_t;

    state_t                  r_state;
    logic [IW-1:0]           r_in;
    logic [OW-1:0]           r_out;
    logic signed [AW-1:0]    r_acc;
    logic [N*NI-1:0]         r_x;
    logic [N*NI*NO-1:0]      r_w;
    logic [N*NO-1:0]         r_b;
    logic [N*NO-1:0]         r_dout;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_ovf;

    logic [N-1:0]            w_x;
    logic [N-1:0]            w_w;
    logic [N-1:0]            w_b_nxt;
    logic signed [2*N-1:0]   w_prod;
    logic signed [AW-1:0]    w_r;
    logic                    w_ovf;
    logic [N-1:0]            w_res;
    logic                    w_last_in;
    logic                    w_last_out;

    assign w_x        = r_x[r_in*N +: N];
    assign w_w        = r_w[(r_in*NO + r_out)*N +: N];
    assign w_b_nxt    = r_b[(r_out + 1)*N +: N];
    assign w_prod     = $signed(w_x) * $signed(w_w);
    assign w_r        = r_acc >>> Q;
    // In range only when every bit above the N-bit sign bit copies it
    assign w_ovf      = w_r[AW-1:N-1] != {(AW-N+1){w_r[N-1]}};
    assign w_last_in  = r_in == IW'(NI-1);
    assign w_last_out = r_out == OW'(NO-1);
`ifdef HIDDEN_OUTPUT_SAT_EN
    assign w_res = w_ovf ? (w_r[AW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}}) : w_r[N-1:0];
`else
    assign w_res = w_r[N-1:0];
`endif

    assign o_data_out = r_dout;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_overflow = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_in    <= '0;
            r_out   <= '0;
            r_acc   <= '0;
            r_x     <= '0;
            r_w     <= '0;
            r_b     <= '0;
            r_dout  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (i_fire) begin
                    r_x     <= i_data_in;
                    r_w     <= i_weight_mem;
                    r_b     <= i_bias_mem;
                    r_in    <= '0;
                    r_out   <= '0;
                    r_acc   <= AW'($signed(i_bias_mem[N-1:0])) <<< Q;
                    r_ovf   <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= MAC;
                end
                MAC: begin
                    r_acc <= r_acc + AW'(w_prod);
                    if (w_last_in) r_state <= WB;
                    else r_in <= r_in + 1'b1;
                end
                WB: begin
                    r_dout[r_out*N +: N] <= w_res;
                    if (w_ovf) r_ovf <= 1'b1;
                    if (w_last_out) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_out   <= r_out + 1'b1;
                        r_in    <= '0;
                        r_acc   <= AW'($signed(w_b_nxt)) <<< Q;
                        r_state <= MAC;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hidden_output_layer.sv
// tb_hidden_output_layer: directed vectors for the 2x2 build plus a 4x3 instance against a reference model.
module tb_hidden_output_layer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]  x, b, dout;
    logic [63:0]  w;
    logic         fire, busy, done, ovf;
    logic [63:0]  x2;
    logic [191:0] w2;
    logic [47:0]  b2, dout2;
    logic         fire2, busy2, done2, ovf2;

    hidden_output_layer u1 (
        .clk(clk), .rst(rst), .i_data_in(x), .i_weight_mem(w), .i_bias_mem(b), .i_fire(fire),
        .o_data_out(dout), .o_busy(busy), .o_done(done), .o_overflow(ovf)
    );

    hidden_output_layer #(.Q(13), .N(16), .NUM_OF_INPUTS(4), .NUM_OF_OUTPUTS(3)) u2 (
        .clk(clk), .rst(rst), .i_data_in(x2), .i_weight_mem(w2), .i_bias_mem(b2), .i_fire(fire2),
        .o_data_out(dout2), .o_busy(busy2), .o_done(done2), .o_overflow(ovf2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] x;
        logic [63:0] w;
        logic [31:0] b;
        logic [31:0] e;
        logic        ov;
    } vec_t;
    vec_t tv[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic run(input bit sel, output int lat);
        @(negedge clk);
        if (sel) fire2 = 1'b1; else fire = 1'b1;
        @(posedge clk);
        #1 fire = 1'b0;
        fire2 = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (sel ? done2 : done) break;
        end
    endtask

    task automatic load(input int k);
        x = tv[k].x;
        w = tv[k].w;
        b = tv[k].b;
    endtask

    int lat, e0, d1, d2, seen;
    logic [47:0] e2;
    logic        eov;
    longint      acc, r;

    initial begin
        tv[0] = '{32'h2000_2000, 64'h1000_1000_1000_1000, 32'h2000_0000, 32'h4000_2000, 1'b0};
        tv[1] = '{32'hFFFF_0001, 64'h0001_0001_0001_0001, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tv[2] = '{32'h0000_FFFF, 64'h0001_0001_0001_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
`ifdef HIDDEN_OUTPUT_SAT_EN
        tv[3] = '{32'h7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 1'b1};
        tv[5] = '{32'h8000_8000, 64'h7FFF_7FFF_7FFF_7FFF, 32'h8000_8000, 32'h8000_8000, 1'b1};
`else
        tv[3] = '{32'h7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FEF_7FEF, 1'b1};
        tv[5] = '{32'h8000_8000, 64'h7FFF_7FFF_7FFF_7FFF, 32'h8000_8000, 32'h8008_8008, 1'b1};
`endif
        tv[4] = '{32'h4000_2000, 64'h1000_E000_1000_E000, 32'h0800_0000, 32'h3800_A000, 1'b0};

        rst = 1'b1; fire = 1'b0; fire2 = 1'b0;
        x = '0; w = '0; b = '0; x2 = '0; w2 = '0; b2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_dout", 64'(dout), 64'h0);
        chk("reset_flags", {61'b0, busy, done, ovf}, 64'h0);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            load(k);
            run(1'b0, lat);
            chk($sformatf("vec%0d_latency", k), 64'(lat), 64'd6);
            chk($sformatf("vec%0d_dout", k), 64'(dout), 64'(tv[k].e));
            chk($sformatf("vec%0d_ovf", k), 64'(ovf), 64'(tv[k].ov));
            chk($sformatf("vec%0d_busy_at_done", k), 64'(busy), 64'h0);
        end

        // fire held while busy with new operands: ignored until the edge after done
        load(0);
        @(negedge clk);
        fire = 1'b1;
        @(posedge clk);
        #1 fire = 1'b0;
        e0 = cyc;
        @(negedge clk);
        chk("busy_high_mid_run", 64'(busy), 64'h1);
        repeat (2) @(posedge clk);
        #1 fire = 1'b1;
        load(4);
        d1 = -1;
        for (int i = 0; i < 20 && d1 < 0; i++) begin
            @(negedge clk);
            if (done) d1 = cyc;
        end
        chk("b2b_first_latency", 64'(d1 - e0), 64'd6);
        chk("b2b_first_dout", 64'(dout), 64'h4000_2000);
        @(posedge clk);
        #1 fire = 1'b0;
        d2 = -1;
        for (int i = 0; i < 20 && d2 < 0; i++) begin
            @(negedge clk);
            if (done) d2 = cyc;
        end
        chk("b2b_done_spacing", 64'(d2 - d1), 64'd7);
        chk("b2b_second_dout", 64'(dout), 64'h3800_A000);

        // reset three cycles into a run aborts it without done
        load(4);
        @(negedge clk);
        fire = 1'b1;
        @(posedge clk);
        #1 fire = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_dout", 64'(dout), 64'h0);
        chk("midrst_flags", {61'b0, busy, done, ovf}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midrst_no_done", 64'(seen), 64'h0);
        load(0);
        run(1'b0, lat);
        chk("post_rst_latency", 64'(lat), 64'd6);
        chk("post_rst_dout", 64'(dout), 64'h4000_2000);

        // 4-input, 3-output instance against a bit-exact reference
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 12; k++)
                w2[k*16 +: 16] = (t < 2) ? 16'($urandom) : 16'($urandom_range(0, 16383)) - 16'd8192;
            for (int k = 0; k < 4; k++)
                x2[k*16 +: 16] = (t < 2) ? 16'($urandom) : 16'($urandom_range(0, 16383)) - 16'd8192;
            for (int k = 0; k < 3; k++)
                b2[k*16 +: 16] = (t < 2) ? 16'($urandom) : 16'($urandom_range(0, 16383)) - 16'd8192;
            eov = 1'b0;
            for (int o = 0; o < 3; o++) begin
                acc = longint'(shortint'(b2[o*16 +: 16])) * 8192;
                for (int i = 0; i < 4; i++)
                    acc += longint'(shortint'(x2[i*16 +: 16])) * longint'(shortint'(w2[(i*3+o)*16 +: 16]));
                r = acc >>> 13;
                if (r > 32767 || r < -32768) eov = 1'b1;
`ifdef HIDDEN_OUTPUT_SAT_EN
                e2[o*16 +: 16] = r > 32767 ? 16'h7FFF : r < -32768 ? 16'h8000 : r[15:0];
`else
                e2[o*16 +: 16] = r[15:0];
`endif
            end
            run(1'b1, lat);
            chk($sformatf("sweep%0d_latency", t), 64'(lat), 64'd15);
            chk($sformatf("sweep%0d_dout", t), 64'(dout2), 64'(e2));
            chk($sformatf("sweep%0d_ovf", t), 64'(ovf2), 64'(eov));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hidden_output_layer.md
# hidden_output_layer

Output-layer stage fed by the hidden-layer block: takes its hidden activations, forms one weighted sum plus bias per output neuron, and presents raw Q-format scores to the classifier logic. A single time-multiplexed signed MAC computes neurons one after another, trading latency for area. The block is sequenced by a `fire`/`done` handshake matching the upstream layers.

## Interface
- `Q`, 13, fractional bits of every data, weight and bias word (signed two's complement).
- `N`, 16, word width.
- `NUM_OF_INPUTS`, 2, hidden activations consumed (≥1).
- `NUM_OF_OUTPUTS`, 2, output neurons computed (≥1).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset. Asynchronous, active-high; clears all state.
- `data_in`  in  N × NUM_OF_INPUTS  hidden activations; sampled on fire acceptance.
- `WeightMem`  in  N × NUM_OF_INPUTS × NUM_OF_OUTPUTS  weight `[i][o]`; sampled on fire acceptance.
- `BiasMem`  in  N × NUM_OF_OUTPUTS  per-neuron bias; sampled on fire acceptance.
- `fire`  in  1  start request; honoured only while idle.
- `data_out`  out  N × NUM_OF_OUTPUTS  registered neuron results.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse: all `data_out` valid.
- `overflow`  out  1  some neuron result this run exceeded N-bit range; valid with `done`.

## Operation
- FSM states: IDLE, MAC, WB. Indices `in_idx` (0..NUM_OF_INPUTS-1), `out_idx` (0..NUM_OF_OUTPUTS-1).
- IDLE, `fire`=1: latch `data_in`, `WeightMem`, `BiasMem`; `out_idx`=0, `in_idx`=0; `acc` = sext(BiasMem[0]) << Q; clear `overflow`; go MAC.
- MAC: `acc += data_in[in_idx] * WeightMem[in_idx][out_idx]` (full 2N-bit signed product, 2Q fractional bits). Last `in_idx` → WB, else `in_idx`++.
- WB: `r = acc >>> Q` (arithmetic shift, floor rounding). Write `data_out[out_idx]` per Configuration; set `overflow` if `r` outside [-2^(N-1), 2^(N-1)-1]. If last `out_idx`: pulse `done`, go IDLE. Else `out_idx`++, `in_idx`=0, `acc` = sext(BiasMem[out_idx+1]) << Q, go MAC.
- `acc` width: 2N + clog2(NUM_OF_INPUTS) + 1 bits; never wraps internally.
- `fire` while busy: ignored, no queuing. Latched operands make input changes during a run invisible.
- `data_out[o]` holds its value until rewritten in a later run's WB for neuron o; earlier neurons update before `done` of that run.
- Reset (any time, incl. mid-run): state IDLE, `data_out` all 0, `busy`/`done`/`overflow` 0, `acc` 0. Aborted run produces no `done`.

## Timing
- Fire accepted at edge E0. Neuron o written at edge E0 + (o+1)(NUM_OF_INPUTS+1).
- `done` high for exactly the cycle after edge E0 + NUM_OF_OUTPUTS·(NUM_OF_INPUTS+1) (defaults: 6 edges). `overflow` and all `data_out` stable in that cycle.
- `busy` rises after E0 and falls with `done` rising; a new `fire` is accepted at the very next edge (back-to-back runs, no dead cycle).
- `done` and `busy` never high together.

## Configuration
- `HIDDEN_OUTPUT_SAT_EN` defined: WB writes `r` clamped to [0x8000, 0x7FFF] (N=16).
- Not defined: WB writes `r[N-1:0]` (wrap-around).
- `overflow` detection identical in both builds.

## Test plan
- Basic: x={0x2000,0x2000}, all W=0x1000, B={0x0000,0x2000}, fire → `done` 6 cycles after acceptance; `data_out`={0x2000,0x4000}; `overflow`=0.
- Signed/floor: x={0x0001,0xFFFF}, W[0][0]=W[1][0]=0x0001, B[0]=0 → `data_out[0]`=0x0000; with x={0xFFFF,0x0000} → 0xFFFF (−1 LSB, floor).
- Saturation: x, W, B all 0x7FFF → `overflow`=1; SAT_EN build `data_out`={0x7FFF,0x7FFF}; non-SAT build equals low 16 bits of `acc>>>13` from reference model.
- Busy handling: fire, then fire held high 3 cycles later with changed `data_in` → results match first operands only; second run starts at edge after `done`, its `done` exactly 7 edges after the first's.
- Reset mid-run: assert `rst` 3 cycles after fire → `data_out`=0, `busy`=0, no `done`; fire after release gives correct Basic results.
- Parameter sweep: NUM_OF_INPUTS=4, NUM_OF_OUTPUTS=3, random Q2.13 operands → matches bit-exact model; `done` latency 15 edges.
